// File: rtl/if_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : if_fetch_unit                                                |
// | Brief   : Fetch stage: PC, single-outstanding ROM handshake, IF/ID reg |
// |           Optional perf counters under IF_FETCH_PERF_CNT_EN.           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] jump_addr_i,
  input  logic        jump_en_i,
  input  logic        hold_flag_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_inst_addr_o,
  output logic        if_valid_o
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [15:0] discard_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_BUF     = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_inst_addr, w_inst_addr_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_buf_inst, r_buf_addr;
  logic        w_buf_load;
  logic        w_req;
  logic        w_load;
  logic        w_drop;
  logic        w_outstanding;

  // A response is still owed by memory in WAIT and DISCARD.
  assign w_outstanding = (r_state == S_WAIT) || (r_state == S_DISCARD);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_inst_nxt      = r_inst;
    w_inst_addr_nxt = r_inst_addr;
    w_valid_nxt     = r_valid;
    w_buf_load      = 1'b0;
    w_req           = 1'b0;
    w_load          = 1'b0;
    w_drop          = 1'b0;

    if (r_state == S_IDLE) begin
      w_state_nxt = S_REQ;
      if (!hold_flag_i) begin
        w_inst_nxt      = NOP_INST;
        w_inst_addr_nxt = 32'd0;
        w_valid_nxt     = 1'b0;
      end
    end else if (jump_en_i) begin
      w_pc_nxt        = jump_addr_i & c_align_mask;
      w_inst_nxt      = NOP_INST;
      w_inst_addr_nxt = 32'd0;
      w_valid_nxt     = 1'b0;
      w_state_nxt     = (w_outstanding && !rom_rvalid_i) ? S_DISCARD : S_REQ;
      w_drop          = (w_outstanding && rom_rvalid_i) || (r_state == S_BUF);
    end else if (hold_flag_i) begin
      case (r_state)
        S_WAIT: begin
          if (rom_rvalid_i) begin
            w_buf_load  = 1'b1;
            w_state_nxt = S_BUF;
          end
        end
        S_DISCARD: begin
          if (rom_rvalid_i) begin
            w_drop      = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
        default: ;
      endcase
    end else begin
      w_inst_nxt      = NOP_INST;
      w_inst_addr_nxt = 32'd0;
      w_valid_nxt     = 1'b0;
      case (r_state)
        S_REQ: begin
          w_req       = 1'b1;
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (rom_rvalid_i) begin
            w_load          = 1'b1;
            w_inst_nxt      = rom_rdata_i;
            w_inst_addr_nxt = r_pc;
            w_valid_nxt     = 1'b1;
            w_pc_nxt        = r_pc + 32'd4;
            w_state_nxt     = S_REQ;
          end
        end
        S_BUF: begin
          w_load          = 1'b1;
          w_inst_nxt      = r_buf_inst;
          w_inst_addr_nxt = r_buf_addr;
          w_valid_nxt     = 1'b1;
          w_pc_nxt        = r_pc + 32'd4;
          w_state_nxt     = S_REQ;
        end
        S_DISCARD: begin
          if (rom_rvalid_i) begin
            w_drop      = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= NOP_INST;
      r_inst_addr <= 32'd0;
      r_valid     <= 1'b0;
      r_buf_inst  <= 32'd0;
      r_buf_addr  <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_inst      <= w_inst_nxt;
      r_inst_addr <= w_inst_addr_nxt;
      r_valid     <= w_valid_nxt;
      if (w_buf_load) begin
        r_buf_inst <= rom_rdata_i;
        r_buf_addr <= r_pc;
      end
    end
  end

  assign rom_req_o      = w_req;
  assign rom_addr_o     = r_pc;
  assign if_inst_o      = r_inst;
  assign if_inst_addr_o = r_inst_addr;
  assign if_valid_o     = r_valid;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_discard_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt   <= 32'd0;
      r_discard_cnt <= 16'd0;
    end else begin
      if (w_load) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_drop) r_discard_cnt <= r_discard_cnt + 16'd1;
    end
  end

  assign fetch_cnt_o   = r_fetch_cnt;
  assign discard_cnt_o = r_discard_cnt;
`else
  // Load/drop strobes only feed the optional counters.
  logic w_unused;
  assign w_unused = w_load ^ w_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_if_fetch_unit                                             |
// | Brief   : Directed self-checking bench for if_fetch_unit               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] jump_addr_i;
  logic        jump_en_i;
  logic        hold_flag_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_inst_addr_o;
  logic        if_valid_o;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [15:0] discard_cnt_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .jump_addr_i    (jump_addr_i),
    .jump_en_i      (jump_en_i),
    .hold_flag_i    (hold_flag_i),
    .rom_req_o      (rom_req_o),
    .rom_addr_o     (rom_addr_o),
    .rom_rvalid_i   (rom_rvalid_i),
    .rom_rdata_i    (rom_rdata_i),
    .if_inst_o      (if_inst_o),
    .if_inst_addr_o (if_inst_addr_o),
    .if_valid_o     (if_valid_o)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o    (fetch_cnt_o),
    .discard_cnt_o  (discard_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'd0, rom_req_o}, {31'd0, req});
    chk({tag, ".addr"}, rom_addr_o, addr);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                          input logic valid);
    chk({tag, ".inst"}, if_inst_o, inst);
    chk({tag, ".iaddr"}, if_inst_addr_o, addr);
    chk({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, valid});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic j, input logic [31:0] ja,
                       input logic rv, input logic [31:0] rd);
    hold_flag_i  = h;
    jump_en_i    = j;
    jump_addr_i  = ja;
    rom_rvalid_i = rv;
    rom_rdata_i  = rd;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #10;
    chk_req("rst", 0, 32'h0);
    chk_ifid("rst", NOP, 0, 0);

    // Zero-wait fetches returning address as data
    tick; rst = 1'b0;
    drive(0, 0, 0, 0, 0);         chk_req("idle", 0, 0); chk_ifid("idle", NOP, 0, 0);
    tick; drive(0, 0, 0, 0, 0);   chk_req("req0", 1, 32'h0);
    tick; drive(0, 0, 0, 1, 32'h0); chk_req("wait0", 0, 32'h0); chk_ifid("wait0", NOP, 0, 0);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("f0", 32'h0, 32'h0, 1); chk_req("req4", 1, 32'h4);
    tick; drive(0, 0, 0, 1, 32'h4); chk_ifid("bub0", NOP, 0, 0); chk_req("wait4", 0, 32'h4);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("f4", 32'h4, 32'h4, 1); chk_req("req8", 1, 32'h8);
    tick; drive(0, 0, 0, 1, 32'h8); chk_ifid("bub1", NOP, 0, 0);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("f8", 32'h8, 32'h8, 1); chk_req("reqC", 1, 32'hC);

    // Jump in WAIT, old response arrives 3 cycles after its request
    tick; drive(0, 1, 32'h0000_0103, 0, 0); chk_req("jmp_noreq", 0, 32'hC);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("jmp_nop", NOP, 0, 0); chk_req("disc0", 0, 32'h100);
    tick; drive(0, 0, 0, 1, 32'hBAD0_BAD0); chk_req("disc1", 0, 32'h100);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("drop", NOP, 0, 0); chk_req("req100", 1, 32'h100);

    // Jump and rvalid together in WAIT: no DISCARD
    tick; drive(0, 1, 32'h9, 1, 32'h1111_1111); chk_req("jrv_noreq", 0, 32'h100);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("jrv_drop", NOP, 0, 0); chk_req("req8b", 1, 32'h8);

    // Hold for 4 cycles while response arrives
    tick; drive(1, 0, 0, 1, 32'hDEAD_BEEF); chk_req("hold_wait", 0, 32'h8);
    tick; drive(1, 0, 0, 0, 0);   chk_ifid("frz0", NOP, 0, 0);
    tick; drive(1, 0, 0, 0, 0);
    tick; drive(1, 0, 0, 0, 0);   chk_ifid("frz1", NOP, 0, 0); chk_req("buf_noreq", 0, 32'h8);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("frz2", NOP, 0, 0);
    tick; drive(1, 0, 0, 0, 0);   chk_ifid("bufout", 32'hDEAD_BEEF, 32'h8, 1); chk_req("req_hold", 0, 32'hC);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("frzv", 32'hDEAD_BEEF, 32'h8, 1); chk_req("reqC2", 1, 32'hC);

    // Jump with hold while in BUF
    tick; drive(1, 0, 0, 1, 32'h2222_2222); chk_ifid("bub2", NOP, 0, 0);
    tick; drive(1, 1, 32'h0000_0200, 0, 0); chk_req("jb_noreq", 0, 32'hC);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("jb_nop", NOP, 0, 0); chk_req("req200", 1, 32'h200);
    tick; drive(0, 0, 0, 1, 32'h3333_3333);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("f200", 32'h3333_3333, 32'h200, 1); chk_req("req204", 1, 32'h204);

    // PC wrap-around
    tick; drive(0, 1, 32'hFFFF_FFFE, 1, 32'h44);
    tick; drive(0, 0, 0, 0, 0);   chk_req("reqtop", 1, 32'hFFFF_FFFC); chk_ifid("topnop", NOP, 0, 0);
    tick; drive(0, 0, 0, 1, 32'h5555_5555);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("ftop", 32'h5555_5555, 32'hFFFF_FFFC, 1); chk_req("wrap", 1, 32'h0);
    tick; drive(0, 0, 0, 1, 32'h66);
    tick; drive(0, 0, 0, 0, 0);   chk_ifid("f0b", 32'h66, 32'h0, 1); chk_req("req4b", 1, 32'h4);

    // Reset asserted in the middle of a WAIT cycle
    tick; drive(0, 0, 0, 0, 0);   chk_req("wait4b", 0, 32'h4);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt_o, 32'd7);
    chk("discard_cnt", {16'd0, discard_cnt_o}, 32'd4);
`endif
    #2; rst = 1'b1; #1;
    chk_req("arst", 0, 32'h0);
    chk_ifid("arst", NOP, 0, 0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("fetch_cnt_rst", fetch_cnt_o, 32'd0);
    chk("discard_cnt_rst", {16'd0, discard_cnt_o}, 32'd0);
`endif
    tick; rst = 1'b0;
    drive(0, 0, 0, 0, 0);         chk_req("idle2", 0, 32'h0);
    tick; drive(0, 0, 0, 0, 0);   chk_req("rst_req", 1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
